usb_endpoint_tx_arbiter: RTL and testbench
==========================================

# usb_endpoint_tx_arbiter

Shares one USB full-speed IN endpoint transaction interface between `N_REQ` packet producers. Each producer is an endpoint sender that presents a whole packet of up to `MAX_PKT` bytes with a valid/ready handshake. The arbiter grants producers round-robin and holds each grant for exactly one packet, so packets are never interleaved. It sits between the producers and the USB transaction engine's endpoint port.

## Interface
- `N_REQ`, default 4: number of producers; legal range 2..16.
- `MAX_PKT`, default 8: maximum packet payload in bytes.
- `i_clk` input 1: sole clock.
- `i_rst_n` input 1: asynchronous active-low reset.
- `o_reqReady` output N_REQ: per-producer etReady, one-hot or zero.
- `i_reqValid` input N_REQ: per-producer etValid.
- `i_reqData` input N_REQ*8*MAX_PKT: packed producer payloads; producer i occupies slice i.
- `i_reqData_nBytes` input N_REQ*($clog2(MAX_PKT)+1): packed producer byte counts.
- `i_reqStall` input N_REQ: per-producer halt request.
- `i_etReady` input 1: transaction engine takes the packet.
- `o_etValid` output 1: packet offered to the engine.
- `o_etData` output 8*MAX_PKT: payload of the granted producer.
- `o_etData_nBytes` output $clog2(MAX_PKT)+1: byte count of the granted producer.
- `o_etStall` output 1: stall request of the granted producer.
- `o_grant` output N_REQ: registered one-hot grant vector, for debug and monitors.
- `o_nPkts` output 16: count of accepted packets, wraps modulo 2^16.

## Operation
- The FSM has two states, IDLE and OWNED. Reset enters IDLE with `grant_q=0`, `last_q=N_REQ-1`, and `nPkts_q=0`.
- **IDLE:** if any bit of `i_reqValid` is set, select the first set index searching upward from `last_q+1` modulo N_REQ. Register `grant_q` as one-hot on that index and go to OWNED. Otherwise stay in IDLE.
- **OWNED:** selected index g.
  - `o_etValid = i_reqValid[g]`.
  - `o_etData` and `o_etData_nBytes` are slice g.
  - `o_etStall = i_reqStall[g]`.
  - `o_reqReady[g] = i_etReady`; all other ready bits are 0.
- **Acceptance:** `i_etReady && o_etValid` while OWNED.
  - Next state is IDLE, `last_q` becomes g, `grant_q` becomes 0, and `nPkts_q` increments.
- **Withdrawal:** in OWNED, `i_reqValid[g]` low with `i_etReady` low means the producer withdrew. Return to IDLE with `last_q` set to g and no count.
- **Outputs in IDLE:** `o_etValid=0`, `o_etData=0`, `o_etData_nBytes=0`, `o_etStall=0`, `o_reqReady=0`.
- **Reset values:** every output is 0 at reset. A reset asserted mid-packet drops the grant immediately and asynchronously, with no acceptance counted.
- **Fairness:** non-granted producers see ready=0 and must hold their packet. A producer that is continuously valid is granted within N_REQ packets.

## Timing
- Grant latency is 1 cycle. Valid seen in IDLE at cycle t gives OWNED with `o_etValid` high at t+1.
- The output path is combinational from `grant_q` and the producer inputs. There are no data registers.
- Acceptance at cycle t gives IDLE at t+1. The earliest next grant takes effect at t+2, so consecutive packets are at least 2 cycles apart.
- `o_reqReady[g]` is high only in the cycle the engine accepts. Producers clear their valid on that same edge.
- `o_nPkts` updates the cycle after acceptance.

## Structure
- A shared package `usbArbPkg` holds `nBytesWidth(MAX_PKT)` and the FSM state encoding (IDLE=0, OWNED=1).
- One sub-module, `rrPriorityPick`, is parameterised by N. It takes a request vector and `last_q` and returns a one-hot pick plus an index. It is combinational, using a doubled-vector mask search, and is reusable for other endpoint arbiters.

## Test plan
- **Single producer:** N_REQ=4, producer 2 valid with nBytes=3 and data 0xAA,0xBB,0xCC, `i_etReady` held high.
  - `o_grant=4'b0100` at t+1.
  - `o_etData_nBytes=3` and the payload matches at t+1.
  - `o_reqReady[2]` pulses high at t+1.
  - IDLE at t+2 and `o_nPkts=1`.
- **All producers valid, engine always ready:** the grant order is 0,1,2,3,0 and each packet completes. Accepted packets are spaced at least 2 cycles apart.
- **Engine backpressure:** `i_etReady` low for 5 cycles while owned by producer 1.
  - `o_etValid` stays high with data stable.
  - `o_reqReady=0` throughout.
  - Acceptance occurs only when ready rises.
- **Stall passthrough and withdrawal:**
  - Granted producer 3 asserts `i_reqStall`, so `o_etStall=1` in the same cycle.
  - Producer 3 drops valid before acceptance, so the FSM returns to IDLE, `o_nPkts` is unchanged, and the next grant goes to producer 0.
- **Reset mid-packet:** `i_rst_n` low while OWNED.
  - All outputs are 0 asynchronously.
  - After release, the first grant goes to producer 0 even if all producers are valid.
- **Counter wrap:** preload 65535 accepted packets (or force the count), then accept one more, so `o_nPkts=0`.

Source files
------------

// File: rtl/usb_endpoint_tx_arbiter_pkg.sv
// Shared definitions for the USB IN-endpoint transmit arbiter family.
package usbArbPkg;

  function automatic int nBytesWidth(input int maxPkt);
    return $clog2(maxPkt) + 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arbState_t;

endpackage

// File: rtl/usb_endpoint_tx_arbiter_if.sv
// Producer-side and engine-side packet handshake bundle for the TX arbiter.
interface usb_endpoint_tx_arbiter_if
  import usbArbPkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_PKT = 8
);
  localparam int NBW = nBytesWidth(MAX_PKT);

  logic [N_REQ-1:0]                  reqReady;
  logic [N_REQ-1:0]                  reqValid;
  logic [N_REQ-1:0]                  reqStall;
  logic [N_REQ-1:0][8*MAX_PKT-1:0]   reqData;
  logic [N_REQ-1:0][NBW-1:0]         reqData_nBytes;
  logic                              etReady;
  logic                              etValid;
  logic                              etStall;
  logic [8*MAX_PKT-1:0]              etData;
  logic [NBW-1:0]                    etData_nBytes;

  // slave: the arbiter; master: producers plus transaction engine
  modport slave (
    input  reqValid, reqStall, reqData, reqData_nBytes, etReady,
    output reqReady, etValid, etStall, etData, etData_nBytes
  );
  modport master (
    output reqValid, reqStall, reqData, reqData_nBytes, etReady,
    input  reqReady, etValid, etStall, etData, etData_nBytes
  );
endinterface

// File: rtl/usb_endpoint_tx_arbiter_rrPriorityPick.sv
// Combinational round-robin pick: first set request strictly after i_last, wrapping.
module rrPriorityPick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_pick,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);
  localparam int IW = $clog2(N);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_low;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) w_mask[i] = (i > int'(i_last));
  end

  // Lower half holds requests above i_last, upper half the full vector as the wrap.
  assign w_dbl  = {i_req, i_req & w_mask};
  assign w_low  = w_dbl & (-w_dbl);
  assign o_pick = w_low[N-1:0] | w_low[2*N-1:N];
  assign o_any  = |i_req;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) if (o_pick[i]) o_idx = IW'(i);
  end
endmodule

// File: rtl/usb_endpoint_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one USB IN endpoint among N_REQ producers.
module usb_endpoint_tx_arbiter
  import usbArbPkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_PKT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  usb_endpoint_tx_arbiter_if.slave   et_bus,
  output logic [N_REQ-1:0]           o_grant,
  output logic [15:0]                o_nPkts
);
  localparam int IW = $clog2(N_REQ);

  arbState_t          r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [IW-1:0]      r_gIdx;
  logic [IW-1:0]      r_last;
  logic [15:0]        r_nPkts;

  logic [N_REQ-1:0]   w_pick;
  logic [IW-1:0]      w_pickIdx;
  logic               w_any;
  logic               w_owned;
  logic               w_gValid;
  logic               w_accept;
  logic               w_withdraw;

  rrPriorityPick #(.N(N_REQ)) u_pick (
    .i_req  (et_bus.reqValid),
    .i_last (r_last),
    .o_pick (w_pick),
    .o_idx  (w_pickIdx),
    .o_any  (w_any)
  );

  assign w_owned    = (r_state == OWNED);
  assign w_gValid   = w_owned & et_bus.reqValid[r_gIdx];
  assign w_accept   = w_gValid & et_bus.etReady;
  assign w_withdraw = w_owned & ~et_bus.reqValid[r_gIdx] & ~et_bus.etReady;

  // Output mux is purely combinational off the registered grant.
  assign et_bus.etValid       = w_gValid;
  assign et_bus.etStall       = w_owned & et_bus.reqStall[r_gIdx];
  assign et_bus.etData        = w_owned ? et_bus.reqData[r_gIdx] : '0;
  assign et_bus.etData_nBytes = w_owned ? et_bus.reqData_nBytes[r_gIdx] : '0;
  assign et_bus.reqReady      = et_bus.etReady ? r_grant : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gIdx  <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_nPkts <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= OWNED;
            r_grant <= w_pick;
            r_gIdx  <= w_pickIdx;
          end
        end
        OWNED: begin
          // Grant is held for exactly one packet, or until the producer withdraws.
          if (w_accept || w_withdraw) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= r_gIdx;
            if (w_accept) r_nPkts <= r_nPkts + 16'd1;
          end
        end
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_nPkts = r_nPkts;
endmodule

// File: tb/tb_usb_endpoint_tx_arbiter.sv
// Bench for usb_endpoint_tx_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_usb_endpoint_tx_arbiter;
  localparam int N   = 4;
  localparam int MP  = 8;
  localparam int NBW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    grant;
  logic [15:0]     nPkts;

  usb_endpoint_tx_arbiter_if #(.N_REQ(N), .MAX_PKT(MP)) bus ();

  usb_endpoint_tx_arbiter #(.N_REQ(N), .MAX_PKT(MP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .et_bus  (bus),
    .o_grant (grant),
    .o_nPkts (nPkts)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  // packet-level model: owner (-1 = nobody), last served, accepted count
  int          m_own   = -1;
  int          m_last  = N - 1;
  int unsigned m_cnt   = 0;
  int          m_acc   = -1;
  int          dut_acc_q[$];
  int          last_dut_acc = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_last = N - 1;
    m_cnt  = 0;
    m_acc  = -1;
  endtask

  task automatic check_outs();
    logic [N-1:0]  eg, er;
    logic          ev, es;
    logic [63:0]   ed;
    logic [NBW-1:0] en;
    int            gi;
    eg = '0; er = '0; ev = 1'b0; es = 1'b0; ed = '0; en = '0;
    if (m_own >= 0) begin
      eg[m_own] = 1'b1;
      ev = bus.reqValid[m_own];
      es = bus.reqStall[m_own];
      ed = bus.reqData[m_own];
      en = bus.reqData_nBytes[m_own];
      if (bus.etReady) er[m_own] = 1'b1;
    end
    chk("grant",    grant,             eg);
    chk("etValid",  bus.etValid,       ev);
    chk("etStall",  bus.etStall,       es);
    chk("etData",   bus.etData,        ed);
    chk("etNBytes", bus.etData_nBytes, en);
    chk("reqReady", bus.reqReady,      er);
    chk("nPkts",    nPkts,             m_cnt[15:0]);
    // observe the DUT's own accepts for ordering and spacing checks
    if (bus.etValid && bus.etReady) begin
      gi = -1;
      for (int k = 0; k < N; k++) if (grant[k]) gi = k;
      dut_acc_q.push_back(gi);
      if (last_dut_acc >= 0) chk("acc_spacing", ((cyc - last_dut_acc) >= 2), 1);
      last_dut_acc = cyc;
    end
  endtask

  task automatic model_upd();
    m_acc = -1;
    if (!rst_n) begin
      model_reset();
    end else if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (bus.reqValid[(m_last + k) % N]) begin
          m_own = (m_last + k) % N;
          break;
        end
      end
    end else if (bus.etReady && bus.reqValid[m_own]) begin
      m_acc  = m_own;
      m_cnt  = m_cnt + 1;
      m_last = m_own;
      m_own  = -1;
    end else if (!bus.reqValid[m_own] && !bus.etReady) begin
      m_last = m_own;
      m_own  = -1;
    end
  endtask

  // inputs are applied at the negedge before calling; ends at the next negedge
  task automatic step();
    #1;
    check_outs();
    model_upd();
    cyc++;
    @(negedge clk);
  endtask

  task automatic load(input int i, input logic [63:0] d, input int nb, input logic st);
    bus.reqData[i]        = d;
    bus.reqData_nBytes[i] = NBW'(nb);
    bus.reqStall[i]       = st;
    bus.reqValid[i]       = 1'b1;
  endtask

  task automatic retire();
    if (m_acc >= 0) bus.reqValid[m_acc] = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.reqValid       = '0;
    bus.reqStall       = '0;
    bus.reqData        = '0;
    bus.reqData_nBytes = '0;
    bus.etReady        = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    clear_inputs();
    @(negedge clk);
    do_reset();

    // single producer, engine ready
    load(2, 64'h0000_0000_00CC_BBAA, 3, 1'b0);
    bus.etReady = 1'b1;
    step();
    chk("single_grant", grant, 4'b0100);
    step();
    retire();
    chk("single_cnt", nPkts, 1);
    chk("single_idle", grant, 0);
    step();

    // all producers continuously valid, engine always ready
    do_reset();
    dut_acc_q.delete();
    for (int i = 0; i < N; i++) load(i, {$urandom, $urandom}, $urandom_range(0, MP), 1'b0);
    bus.etReady = 1'b1;
    for (int c = 0; c < 16 && dut_acc_q.size() < 5; c++) begin
      step();
      if (m_acc >= 0) load(m_acc, {$urandom, $urandom}, $urandom_range(0, MP), 1'b0);
    end
    chk("rr_count", dut_acc_q.size() >= 5, 1);
    for (int k = 0; k < 5 && k < dut_acc_q.size(); k++) chk("rr_order", dut_acc_q[k], exp_order[k]);

    // backpressure while producer 1 owns the port
    do_reset();
    load(1, 64'h1122_3344_5566_7788, 8, 1'b0);
    step();
    repeat (5) step();
    bus.etReady = 1'b1;
    step();
    retire();
    chk("bp_cnt", nPkts, 1);
    step();

    // stall passthrough, then withdrawal by producer 3
    do_reset();
    load(3, 64'h0000_0000_DEAD_BEEF, 4, 1'b1);
    step();
    load(0, 64'h0000_0000_0000_0055, 1, 1'b0);
    #1 chk("stall_pass", bus.etStall, 1);
    @(negedge clk);
    m_acc = -1;
    // the extra idle-owned cycle above was spent without model update; keep in step
    cyc++;
    bus.reqValid[3] = 1'b0;
    step();
    step();
    chk("wd_cnt", nPkts, 0);
    chk("wd_next", grant, 4'b0001);
    bus.etReady = 1'b1;
    step();
    retire();
    step();

    // asynchronous reset while a packet is owned
    bus.etReady = 1'b0;
    for (int i = 0; i < N; i++) load(i, {$urandom, $urandom}, $urandom_range(0, MP), 1'b1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_valid", bus.etValid, 0);
    chk("rst_ready", bus.reqReady, 0);
    chk("rst_data",  bus.etData, 0);
    chk("rst_nb",    bus.etData_nBytes, 0);
    chk("rst_stall", bus.etStall, 0);
    chk("rst_cnt",   nPkts, 0);
    model_reset();
    @(negedge clk);
    cyc++;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_first", grant, 4'b0001);
    bus.reqValid = '0;
    step();
    step();

    // counter wrap
    force dut.r_nPkts = 16'hFFFF;
    m_cnt = 65535;
    step();
    release dut.r_nPkts;
    step();
    chk("wrap_pre", nPkts, 16'hFFFF);
    load(1, 64'h0000_0000_0000_00A5, 1, 1'b0);
    bus.etReady = 1'b1;
    step();
    step();
    retire();
    chk("wrap", nPkts, 0);
    step();

    // random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.etReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.reqValid[i] && $urandom_range(0, 2) == 0)
          load(i, {$urandom, $urandom}, $urandom_range(0, MP), $urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 7) == 0)
          bus.reqStall[i] = ~bus.reqStall[i];
      end
      if (m_own >= 0 && !bus.etReady && $urandom_range(0, 19) == 0) bus.reqValid[m_own] = 1'b0;
      step();
      retire();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
